// File: rtl/ret_addr_stack.sv
// ret_addr_stack: hardware return-address stack for CALL/RET.
//
// A CALL (PUSH) stores PC_COUNT+1, so the stored value is the address after the call.
// A RET (POP) discards the top entry. RET_ADDR always shows the current top entry
// combinationally, so the program counter can load it in the same cycle as the RET.
//
// Ports
//   CLK       in   clock; all state changes on its rising edge
//   RST_N     in   asynchronous active-low reset
//   PC_COUNT  in   [n-1:0]  current program-counter value
//   PUSH      in   CALL executing: store PC_COUNT+1
//   POP       in   RET executing: drop the top entry
//   CLR_ERR   in   synchronous clear of the sticky OVF/UNF flags
//   RET_ADDR  out  [n-1:0]  top-of-stack address (0 while empty)
//   EMPTY     out  stack holds no entries
//   FULL      out  stack holds DEPTH entries
//   COUNT     out  [$clog2(DEPTH):0]  number of valid entries
//   OVF       out  sticky: push attempted while full
//   UNF       out  sticky: pop attempted while empty
module ret_addr_stack #(
    parameter int n     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [n-1:0]             PC_COUNT,
    input  logic                     PUSH,
    input  logic                     POP,
    input  logic                     CLR_ERR,
    output logic [n-1:0]             RET_ADDR,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE   = AW'(1);
    localparam logic [n-1:0]  ADDR_ONE  = n'(1);

    // Entry storage; not reset, entries at or above COUNT are never observed.
    logic [n-1:0]  mem [DEPTH];

    logic [CW-1:0] count_reg, count_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;

    logic [AW-1:0] wr_idx;   // slot just above the top
    logic [AW-1:0] top_idx;  // current top slot (wraps modulo DEPTH)
    logic [n-1:0]  wr_data;
    logic          empty_int;
    logic          full_int;
    logic          do_push;
    logic          do_pop;
    logic          do_replace;
    logic          ovf_set;
    logic          unf_set;
    logic          wr_en;
    logic [AW-1:0] wr_sel;

    assign empty_int = (count_reg == '0);
    assign full_int  = (count_reg == CNT_DEPTH);

    // Low bits of COUNT address the next free slot; when full they wrap to 0,
    // but a plain push is blocked then, so that slot is never written.
    assign wr_idx  = count_reg[AW-1:0];
    assign top_idx = wr_idx - IDX_ONE;

    // Return address is the one after the CALL; wraps naturally at 2^n-1.
    assign wr_data = PC_COUNT + ADDR_ONE;

    // PUSH+POP on an empty stack degenerates to a push (never full when empty).
    assign do_push    = PUSH && (!POP || empty_int) && !full_int;
    assign do_pop     = POP && !PUSH && !empty_int;
    assign do_replace = PUSH && POP && !empty_int;
    assign ovf_set    = PUSH && !POP && full_int;
    assign unf_set    = POP && !PUSH && empty_int;

    assign wr_en  = do_push || do_replace;
    assign wr_sel = do_replace ? top_idx : wr_idx;

    always_comb begin
        count_next = count_reg;
        if (do_push) begin
            count_next = count_reg + CNT_ONE;
        end else if (do_pop) begin
            count_next = count_reg - CNT_ONE;
        end

        // Setting wins over clearing in the same cycle.
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        if (CLR_ERR) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end
        if (ovf_set) begin
            ovf_next = 1'b1;
        end
        if (unf_set) begin
            unf_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_sel] <= wr_data;
        end
    end

    // Combinational top-of-stack read so RET can use it before the edge.
    assign RET_ADDR = empty_int ? '0 : mem[top_idx];
    assign EMPTY    = empty_int;
    assign FULL     = full_int;
    assign COUNT    = count_reg;
    assign OVF      = ovf_reg;
    assign UNF      = unf_reg;

endmodule

// File: tb/tb_ret_addr_stack.sv
module tb_ret_addr_stack;

    logic       clk;
    logic       rst_n;
    logic [7:0] pc_count;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] ret_addr;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic       unf;

    int n_tests = 0;
    int n_fail  = 0;

    ret_addr_stack #(.n(8), .DEPTH(8)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .PC_COUNT (pc_count),
        .PUSH     (push),
        .POP      (pop),
        .CLR_ERR  (clr_err),
        .RET_ADDR (ret_addr),
        .EMPTY    (empty),
        .FULL     (full),
        .COUNT    (count),
        .OVF      (ovf),
        .UNF      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic q, input logic c, input logic [7:0] pc);
        push     = p;
        pop      = q;
        clr_err  = c;
        pc_count = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00);
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_ovf",   32'(ovf),   0);
        check("rst_unf",   32'(unf),   0);
        check("rst_ret",   32'(ret_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic push and pop
        drive(1, 0, 0, 8'h10); step();
        check("push1_ret",   32'(ret_addr), 32'h11);
        check("push1_count", 32'(count), 1);
        drive(1, 0, 0, 8'h40); step();
        check("push2_ret",   32'(ret_addr), 32'h41);
        drive(0, 1, 0, 8'h00); #1;
        check("pop_ret_before_edge", 32'(ret_addr), 32'h41);
        step();
        check("pop1_ret",   32'(ret_addr), 32'h11);
        check("pop1_count", 32'(count), 1);
        step();
        check("pop2_empty", 32'(empty), 1);
        check("pop2_ret",   32'(ret_addr), 0);

        // Stored-address wrap
        drive(1, 0, 0, 8'hFF); step();
        check("wrap_ret",   32'(ret_addr), 0);
        check("wrap_count", 32'(count), 1);
        check("wrap_empty", 32'(empty), 0);
        drive(0, 1, 0, 8'h00); step();
        drive(0, 0, 0, 8'h00); step();
        check("hold_count", 32'(count), 0);

        // Overflow
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 0, 8'(i)); step();
        end
        check("fill_full",  32'(full), 1);
        check("fill_count", 32'(count), 8);
        check("fill_ovf",   32'(ovf), 0);
        drive(1, 0, 0, 8'h20); step();
        check("ovf_full",  32'(full), 1);
        check("ovf_count", 32'(count), 8);
        check("ovf_flag",  32'(ovf), 1);
        check("ovf_ret",   32'(ret_addr), 32'h09);
        // Replace while full: no flag change, count stays
        drive(0, 0, 1, 8'h00); step();
        check("ovf_clr", 32'(ovf), 0);
        drive(1, 1, 0, 8'h08); step();
        check("rep_full_count", 32'(count), 8);
        check("rep_full_ovf",   32'(ovf), 0);
        check("rep_full_ret",   32'(ret_addr), 32'h09);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 8'h00);
            #1;
            check($sformatf("drain_%0d", i), 32'(ret_addr), 32'(9 - i));
            step();
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_full",  32'(full), 0);

        // Underflow and flag clear
        drive(0, 1, 0, 8'h00); step();
        check("unf_flag",  32'(unf), 1);
        check("unf_count", 32'(count), 0);
        drive(0, 0, 0, 8'h00); step();
        check("unf_sticky", 32'(unf), 1);
        drive(0, 0, 1, 8'h00); step();
        check("unf_clr", 32'(unf), 0);
        drive(0, 1, 1, 8'h00); step();
        check("unf_set_wins", 32'(unf), 1);
        drive(0, 0, 1, 8'h00); step();
        check("unf_clr2", 32'(unf), 0);

        // Simultaneous push and pop
        drive(1, 0, 0, 8'h30); step();
        check("sim_pre_ret", 32'(ret_addr), 32'h31);
        drive(1, 1, 0, 8'h50); step();
        check("sim_count", 32'(count), 1);
        check("sim_ret",   32'(ret_addr), 32'h51);
        drive(0, 1, 0, 8'h00); step();
        check("sim_drained", 32'(empty), 1);
        drive(1, 1, 0, 8'h50); step();
        check("sim_empty_count", 32'(count), 1);
        check("sim_empty_ret",   32'(ret_addr), 32'h51);
        check("sim_empty_unf",   32'(unf), 0);

        // Asynchronous reset mid-sequence (one entry present, add two)
        drive(1, 0, 0, 8'h60); step();
        drive(1, 0, 0, 8'h61); step();
        check("ar_count_pre", 32'(count), 3);
        drive(0, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_empty", 32'(empty), 1);
        check("ar_count", 32'(count), 0);
        check("ar_ret",   32'(ret_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 8'h70);
        step();
        check("ar_first_push_count", 32'(count), 1);
        check("ar_first_push_ret",   32'(ret_addr), 32'h71);
        drive(0, 0, 0, 8'h00);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 Parameter n, default 8: address width, equal to the program-counter width.
REQ-002 Parameter DEPTH, default 8: number of stack entries, a power of two and at least 2.
REQ-003 CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1: asynchronous reset, active-low.
REQ-005 PC_COUNT  input  n: current program-counter value from the program counter.
REQ-006 PUSH  input  1: a CALL is executing; store the return address.
REQ-007 POP  input  1: a RET is executing; remove the top entry.
REQ-008 CLR_ERR  input  1: synchronous clear of the sticky error flags.
REQ-009 RET_ADDR  output  n: top-of-stack return address; drives the program counter's DIN path on RET.
REQ-010 EMPTY  output  1: the stack holds zero entries.
REQ-011 FULL  output  1: the stack holds DEPTH entries.
REQ-012 COUNT  output  clog2(DEPTH)+1: number of valid entries, 0..DEPTH.
REQ-013 OVF  output  1: sticky flag; a push was attempted while full.
REQ-014 UNF  output  1: sticky flag; a pop was attempted while empty.

Function
REQ-015 A push SHALL store PC_COUNT+1, truncated to n bits, so that address 2^n-1 wraps to 0.
REQ-016 Push with FULL=0 and POP=0 SHALL write the new entry above the current top and increment COUNT at the same edge.
REQ-017 Pop with EMPTY=0 and PUSH=0 SHALL decrement COUNT at the edge; the popped entry is discarded.
REQ-018 RET_ADDR SHALL be combinational from the current top entry, so it is valid in the same cycle as POP, before the edge; RET_ADDR SHALL be 0 while EMPTY=1.
REQ-019 After a push at edge k, RET_ADDR SHALL equal the pushed value from edge k onward, giving 1-cycle write latency.
REQ-020 PUSH=1, POP=1, EMPTY=0: replace the top entry with PC_COUNT+1, leave COUNT unchanged, and set no flag; this holds even when FULL=1.
REQ-021 PUSH=1, POP=1, EMPTY=1: behave as a push only, with COUNT going to 1 and UNF not set.
REQ-022 PUSH=1, POP=0, FULL=1: leave the contents and COUNT unchanged and set OVF to 1.
REQ-023 POP=1, PUSH=0, EMPTY=1: leave the contents and COUNT unchanged and set UNF to 1.
REQ-024 OVF and UNF SHALL remain 1 until CLR_ERR=1 at an edge or reset; if CLR_ERR and a new error occur in the same cycle, the flag SHALL be 1 after the edge, because setting has priority.
REQ-025 EMPTY SHALL be asserted exactly when COUNT==0, and FULL exactly when COUNT==DEPTH; both are decoded from registered COUNT with no extra latency.
REQ-026 Internal read and write pointers SHALL wrap modulo DEPTH; entries at or above COUNT are don't-care and never visible on RET_ADDR.
REQ-027 With PUSH=POP=CLR_ERR=0, all state SHALL hold.

Reset
REQ-028 RST_N=0 SHALL immediately, without waiting for a clock edge, force COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0 and RET_ADDR=0.
REQ-029 Entry storage need not be cleared on reset.
REQ-030 Deassertion of RST_N SHALL take effect at the first rising CLK edge after release; PUSH or POP on that edge SHALL be honoured.
REQ-031 Reset asserted mid-sequence, for example between two pushes, SHALL discard all entries and leave the stack EMPTY.

Verification
REQ-032 Basic push and pop: reset; PC_COUNT=0x10 with PUSH; PC_COUNT=0x40 with PUSH; then POP twice. Required: RET_ADDR=0x11, then 0x41; after the first POP RET_ADDR=0x11 and COUNT=1; after the second POP EMPTY=1 and RET_ADDR=0.
REQ-033 Wrap of the stored address: PC_COUNT=0xFF with PUSH. Required: RET_ADDR=0x00, COUNT=1.
REQ-034 Overflow: 8 pushes of 0x01..0x08, then PUSH with 0x20. Required: FULL=1, COUNT=8, OVF=1, RET_ADDR=0x09; 8 pops then return 0x09 down to 0x02 in order.
REQ-035 Underflow and flag clear: POP while empty. Required: UNF=1 and COUNT=0; then CLR_ERR alone gives UNF=0; then CLR_ERR together with POP on empty gives UNF=1.
REQ-036 Simultaneous push and pop: with one entry 0x31, PUSH and POP with PC_COUNT=0x50. Required: COUNT=1 and RET_ADDR=0x51; on an empty stack the same stimulus gives COUNT=1, RET_ADDR=0x51 and UNF=0.
REQ-037 Asynchronous reset: with 3 entries, drop RST_N between clock edges. Required: EMPTY=1, COUNT=0 and RET_ADDR=0 before the next edge.
